// File: rtl/rv_mem_wb_pkg.sv
// Shared types for the RV32I memory/write-back stages, plus the flop macros
// used for the Q104H pipeline registers.
`ifndef RV_DFF_MACROS
`define RV_DFF_MACROS
`define DFF(q, d) always_ff @(posedge clk) q <= (d);
`define DFF_RST(q, d, rv) always_ff @(posedge clk) begin if (rst) q <= (rv); else q <= (d); end
`endif

package rv_mem_wb_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } t_mem_size;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } t_wb_sel;

  typedef enum logic [1:0] {
    DMEM_IDLE        = 2'd0,
    DMEM_WAIT_GNT    = 2'd1,
    DMEM_WAIT_RVALID = 2'd2
  } t_dmem_state;

  typedef struct packed {
    logic      valid_Q103H;
    logic      mem_rd_Q103H;
    logic      mem_wr_Q103H;
    t_mem_size mem_size_Q103H;
    logic      mem_unsigned_Q103H;
    t_wb_sel   wb_sel_Q103H;
    logic [4:0] reg_dst_Q103H;
    logic      reg_write_en_Q103H;
  } t_mem_wb_ctrl;

endpackage

// File: rtl/rv_load_align.sv
// Picks the addressed byte/half out of a loaded word and zero/sign extends it.
module rv_load_align
  import rv_mem_wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  t_mem_size   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    case (off_i)
      2'd0:    b_lane = rdata_i[7:0];
      2'd1:    b_lane = rdata_i[15:8];
      2'd2:    b_lane = rdata_i[23:16];
      default: b_lane = rdata_i[31:24];
    endcase
    h_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      MEM_B:   data_o = unsigned_i ? {24'b0, b_lane} : {{24{b_lane[7]}}, b_lane};
      MEM_H:   data_o = unsigned_i ? {16'b0, h_lane} : {{16{h_lane[15]}}, h_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rv_mem_wb.sv
// Memory (Q103H) and write-back (Q104H) stages: data-memory handshake with
// stall generation, load alignment, write-back select and the RF write port.
module rv_mem_wb
  import rv_mem_wb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  t_mem_wb_ctrl ctrl,
  input  logic [31:0]  pc_Q103H,
  input  logic [31:0]  alu_result_Q103H,
  input  logic [31:0]  store_data_Q103H,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [3:0]   dmem_be,
  output logic [31:0]  dmem_wdata,
  input  logic         dmem_gnt,
  input  logic         dmem_rvalid,
  input  logic [31:0]  dmem_rdata,
  output logic         stall_Q103H,
  output logic         misalign_Q104H,
  output logic [31:0]  wb_data_Q104H,
  output logic [4:0]   reg_dst_Q104H,
  output logic         reg_write_en_Q104H
);

  t_dmem_state state_q, state_d;
  logic [1:0]  off;
  logic        mem_op, misaligned, access, gnt_ok, complete;
  logic [31:0] load_data, wb_data_d;
  logic        we_q, we_d, mis_q, mis_d;
  logic [31:0] data_q;
  logic [4:0]  dst_q;

  assign off        = alu_result_Q103H[1:0];
  assign mem_op     = ctrl.valid_Q103H & (ctrl.mem_rd_Q103H | ctrl.mem_wr_Q103H);
  assign misaligned = ((ctrl.mem_size_Q103H == MEM_H) & off[0]) |
                      ((ctrl.mem_size_Q103H == MEM_W) & (off != 2'd0));
  assign access     = mem_op & ~misaligned;

  // Request is combinational so an access can be granted in its first cycle;
  // reset kills it immediately rather than waiting for the state flop.
  assign dmem_req    = ~rst & access & (state_q != DMEM_WAIT_RVALID);
  assign gnt_ok      = dmem_req & dmem_gnt;
  assign complete    = (ctrl.mem_wr_Q103H & gnt_ok) |
                       ((state_q == DMEM_WAIT_RVALID) & dmem_rvalid);
  assign stall_Q103H = ~rst & access & ~complete;

  assign dmem_we   = ctrl.mem_wr_Q103H;
  assign dmem_addr = {alu_result_Q103H[31:2], 2'b00};

  always_comb begin
    case (ctrl.mem_size_Q103H)
      MEM_B: begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{store_data_Q103H[7:0]}};
      end
      MEM_H: begin
        dmem_be    = off[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{store_data_Q103H[15:0]}};
      end
      default: begin
        dmem_be    = 4'hF;
        dmem_wdata = store_data_Q103H;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_IDLE, DMEM_WAIT_GNT: begin
        if (access) begin
          if (gnt_ok) state_d = ctrl.mem_wr_Q103H ? DMEM_IDLE : DMEM_WAIT_RVALID;
          else        state_d = DMEM_WAIT_GNT;
        end else begin
          state_d = DMEM_IDLE;
        end
      end
      DMEM_WAIT_RVALID: if (dmem_rvalid) state_d = DMEM_IDLE;
      default: state_d = DMEM_IDLE;
    endcase
  end

  `DFF_RST(state_q, state_d, DMEM_IDLE)

  rv_load_align u_load_align (
    .rdata_i    (dmem_rdata),
    .off_i      (off),
    .size_i     (ctrl.mem_size_Q103H),
    .unsigned_i (ctrl.mem_unsigned_Q103H),
    .data_o     (load_data)
  );

  always_comb begin
    case (ctrl.wb_sel_Q103H)
      WB_MEM:  wb_data_d = load_data;
      WB_PC4:  wb_data_d = pc_Q103H + 32'd4;
      default: wb_data_d = alu_result_Q103H;
    endcase
  end

  // A stalled slot retires as a bubble; data/dst are don't-care then.
  assign we_d  = ~stall_Q103H & ctrl.valid_Q103H & ctrl.reg_write_en_Q103H &
                 ~(mem_op & misaligned) & (ctrl.reg_dst_Q103H != 5'd0);
  assign mis_d = ~stall_Q103H & mem_op & misaligned;

  `DFF_RST(we_q, we_d, 1'b0)
  `DFF_RST(mis_q, mis_d, 1'b0)
  `DFF_RST(data_q, wb_data_d, 32'd0)
  `DFF_RST(dst_q, ctrl.reg_dst_Q103H, 5'd0)

  assign reg_write_en_Q104H = we_q;
  assign misalign_Q104H     = mis_q;
  assign wb_data_Q104H      = data_q;
  assign reg_dst_Q104H      = dst_q;

endmodule

// File: tb/tb_rv_mem_wb.sv
// Randomised bench for rv_mem_wb against a transaction-level model with a
// bench-owned data memory, plus directed scenarios with literal expectations.
module tb_rv_mem_wb;
  import rv_mem_wb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  t_mem_wb_ctrl ctrl;
  logic [31:0]  pc_Q103H, alu_result_Q103H, store_data_Q103H;
  logic         dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_be;
  logic         stall_Q103H, misalign_Q104H, reg_write_en_Q104H;
  logic [31:0]  wb_data_Q104H;
  logic [4:0]   reg_dst_Q104H;

  rv_mem_wb dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .pc_Q103H(pc_Q103H), .alu_result_Q103H(alu_result_Q103H),
    .store_data_Q103H(store_data_Q103H),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_Q103H(stall_Q103H), .misalign_Q104H(misalign_Q104H),
    .wb_data_Q104H(wb_data_Q104H), .reg_dst_Q104H(reg_dst_Q104H),
    .reg_write_en_Q104H(reg_write_en_Q104H)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [16];

  // values applied at the next step, and expectations for that step
  t_mem_wb_ctrl nxt_ctrl;
  logic [31:0]  nxt_pc, nxt_alu, nxt_sd, nxt_rdata;
  logic         nxt_rst, nxt_gnt, nxt_rvalid;
  logic         exp_req, exp_stall, exp_dwe;
  logic [31:0]  exp_addr, exp_wd;
  logic [3:0]   exp_be;
  logic         np_we, np_mis;
  logic [31:0]  np_data;
  logic [4:0]   np_dst;
  logic         pend_chk, pend_we, pend_mis;
  logic [31:0]  pend_data;
  logic [4:0]   pend_dst;
  logic         obs_req;
  int           stall_cnt;
  logic [3:0]   obs_be;
  logic [31:0]  obs_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    rst = nxt_rst; ctrl = nxt_ctrl; pc_Q103H = nxt_pc; alu_result_Q103H = nxt_alu;
    store_data_Q103H = nxt_sd; dmem_gnt = nxt_gnt; dmem_rvalid = nxt_rvalid;
    dmem_rdata = nxt_rdata;
    @(negedge clk);
    if (pend_chk) begin
      chk("q104_we", 32'(reg_write_en_Q104H), 32'(pend_we));
      chk("q104_misalign", 32'(misalign_Q104H), 32'(pend_mis));
      if (pend_we) begin
        chk("q104_wb_data", wb_data_Q104H, pend_data);
        chk("q104_reg_dst", 32'(reg_dst_Q104H), 32'(pend_dst));
      end
    end
    chk("dmem_req", 32'(dmem_req), 32'(exp_req));
    chk("stall", 32'(stall_Q103H), 32'(exp_stall));
    if (exp_req) begin
      chk("dmem_addr", dmem_addr, exp_addr);
      chk("dmem_we", 32'(dmem_we), 32'(exp_dwe));
      chk("dmem_be", 32'(dmem_be), 32'(exp_be));
      chk("dmem_wdata", dmem_wdata, exp_wd);
    end
    if (dmem_req) begin obs_req = 1'b1; obs_be = dmem_be; obs_wd = dmem_wdata; end
    if (stall_Q103H) stall_cnt++;
    pend_chk = 1'b1; pend_we = np_we; pend_mis = np_mis;
    pend_data = np_data; pend_dst = np_dst;
  endtask

  task automatic idle(input logic stray_rvalid);
    nxt_ctrl = '0; nxt_rst = 1'b0; nxt_gnt = 1'b0; nxt_rvalid = stray_rvalid;
    nxt_rdata = $urandom; nxt_alu = $urandom; nxt_pc = $urandom; nxt_sd = $urandom;
    exp_req = 1'b0; exp_stall = 1'b0; np_we = 1'b0; np_mis = 1'b0;
    step();
  endtask

  function automatic t_mem_wb_ctrl mk(logic v, logic rd, logic wr, t_mem_size sz,
                                      logic u, t_wb_sel ws, logic [4:0] dst, logic we);
    t_mem_wb_ctrl c;
    c.valid_Q103H = v; c.mem_rd_Q103H = rd; c.mem_wr_Q103H = wr;
    c.mem_size_Q103H = sz; c.mem_unsigned_Q103H = u; c.wb_sel_Q103H = ws;
    c.reg_dst_Q103H = dst; c.reg_write_en_Q103H = we;
    return c;
  endfunction

  // One instruction through Q103H: g cycles waiting for grant, then (loads)
  // r cycles until rvalid. Expectations come from the byte-level memory model.
  task automatic run_instr(input t_mem_wb_ctrl c, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] sd, input int g, input int r);
    logic mop, mis, acc, st, rwe;
    int nb, off, idx;
    logic [31:0] ld, mask, res;
    mop = c.valid_Q103H & (c.mem_rd_Q103H | c.mem_wr_Q103H);
    nb  = (c.mem_size_Q103H == MEM_B) ? 1 : (c.mem_size_Q103H == MEM_H) ? 2 : 4;
    off = int'(alu[1:0]);
    idx = int'(alu[5:2]);
    mis = (off % nb) != 0;
    acc = mop & ~mis;
    st  = c.mem_wr_Q103H;
    ld  = mem[idx] >> (8 * off);
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      ld = ld & mask;
      if (!c.mem_unsigned_Q103H && ld[8*nb-1]) ld = ld | ~mask;
    end
    case (c.wb_sel_Q103H)
      WB_ALU:  res = alu;
      WB_PC4:  res = pc + 32'd4;
      default: res = ld;
    endcase
    rwe = c.valid_Q103H & c.reg_write_en_Q103H & ~(mop & mis) & (c.reg_dst_Q103H != 5'd0);
    exp_addr = {alu[31:2], 2'b00};
    exp_dwe  = st;
    exp_be   = 4'((((1 << nb) - 1) << off) & 15);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*(i % nb) +: 8];
    nxt_ctrl = c; nxt_pc = pc; nxt_alu = alu; nxt_sd = sd; nxt_rst = 1'b0;
    np_data = res; np_dst = c.reg_dst_Q103H;
    if (!acc) begin
      exp_req = 1'b0; exp_stall = 1'b0; nxt_gnt = 1'b0;
      nxt_rvalid = 1'($urandom_range(0, 1)); nxt_rdata = $urandom;
      np_we = rwe; np_mis = mop & mis;
      step();
    end else if (st) begin
      for (int k = 0; k <= g; k++) begin
        exp_req = 1'b1; exp_stall = (k < g); nxt_gnt = (k == g);
        nxt_rvalid = (k < g) ? 1'($urandom_range(0, 1)) : 1'b0; nxt_rdata = $urandom;
        np_we = (k == g) ? rwe : 1'b0; np_mis = 1'b0;
        step();
      end
      for (int i = 0; i < 4; i++)
        if (i >= off && i < off + nb) mem[idx][8*i +: 8] = sd[8*(i - off) +: 8];
    end else begin
      for (int k = 0; k <= g; k++) begin
        exp_req = 1'b1; exp_stall = 1'b1; nxt_gnt = (k == g);
        nxt_rvalid = (k < g) ? 1'($urandom_range(0, 1)) : 1'b0; nxt_rdata = $urandom;
        np_we = 1'b0; np_mis = 1'b0;
        step();
      end
      for (int k = 1; k <= r; k++) begin
        exp_req = 1'b0; exp_stall = (k < r); nxt_gnt = 1'b0; nxt_rvalid = (k == r);
        nxt_rdata = (k == r) ? mem[idx] : $urandom;
        np_we = (k == r) ? rwe : 1'b0; np_mis = 1'b0;
        step();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    t_mem_wb_ctrl c;
    int kind;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst = 1'b1; ctrl = '0; pc_Q103H = '0; alu_result_Q103H = '0; store_data_Q103H = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    pend_chk = 1'b0; obs_req = 1'b0; stall_cnt = 0; obs_be = '0; obs_wd = '0;
    nxt_ctrl = '0; nxt_pc = '0; nxt_alu = '0; nxt_sd = '0; nxt_rdata = '0;
    nxt_rst = 1'b1; nxt_gnt = 1'b0; nxt_rvalid = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_dwe = 1'b0; exp_addr = '0; exp_wd = '0; exp_be = '0;
    np_we = 1'b0; np_mis = 1'b0; np_data = '0; np_dst = '0;
    step(); step();
    chk("reset_wb_data", wb_data_Q104H, 32'h0);
    chk("reset_reg_dst", 32'(reg_dst_Q104H), 32'h0);
    chk("reset_we", 32'(reg_write_en_Q104H), 32'h0);
    chk("reset_misalign", 32'(misalign_Q104H), 32'h0);
    idle(1'b0);

    // plain ALU result
    obs_req = 1'b0; stall_cnt = 0;
    run_instr(mk(1, 0, 0, MEM_W, 0, WB_ALU, 5'd5, 1), 32'h100, 32'h1234, 32'h0, 0, 1);
    idle(1'b0);
    chk("alu_wb_data", wb_data_Q104H, 32'h0000_1234);
    chk("alu_reg_dst", 32'(reg_dst_Q104H), 32'd5);
    chk("alu_we", 32'(reg_write_en_Q104H), 32'd1);
    chk("alu_stall_cycles", 32'(stall_cnt), 32'd0);

    // signed byte load from the top lane, slow grant
    mem[0] = 32'h80FF_FF7F;
    stall_cnt = 0;
    run_instr(mk(1, 1, 0, MEM_B, 0, WB_MEM, 5'd7, 1), 32'h104, 32'h103, 32'h0, 2, 1);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    idle(1'b0);
    chk("lb_wb_data", wb_data_Q104H, 32'hFFFF_FF80);

    // halfword store to upper lanes, immediate grant
    obs_req = 1'b0; stall_cnt = 0;
    run_instr(mk(1, 0, 1, MEM_H, 0, WB_ALU, 5'd0, 0), 32'h108, 32'h202, 32'hABCD_1234, 0, 1);
    idle(1'b0);
    chk("sh_be", 32'(obs_be), 32'h0000_000C);
    chk("sh_wdata", obs_wd, 32'h1234_1234);
    chk("sh_stall_cycles", 32'(stall_cnt), 32'd0);
    chk("sh_we", 32'(reg_write_en_Q104H), 32'd0);

    // misaligned word load
    obs_req = 1'b0;
    run_instr(mk(1, 1, 0, MEM_W, 0, WB_MEM, 5'd3, 1), 32'h10C, 32'h101, 32'h0, 0, 1);
    idle(1'b0);
    chk("mis_req_seen", 32'(obs_req), 32'd0);
    chk("mis_pulse", 32'(misalign_Q104H), 32'd1);
    chk("mis_we", 32'(reg_write_en_Q104H), 32'd0);
    idle(1'b0);
    chk("mis_pulse_end", 32'(misalign_Q104H), 32'd0);

    // link address wrap and x0 suppression
    run_instr(mk(1, 0, 0, MEM_W, 0, WB_PC4, 5'd1, 1), 32'hFFFF_FFFC, 32'h55, 32'h0, 0, 1);
    idle(1'b0);
    chk("jal_wb_data", wb_data_Q104H, 32'h0);
    chk("jal_we", 32'(reg_write_en_Q104H), 32'd1);
    run_instr(mk(1, 0, 0, MEM_W, 0, WB_PC4, 5'd0, 1), 32'hFFFF_FFFC, 32'h55, 32'h0, 0, 1);
    idle(1'b0);
    chk("jal_x0_we", 32'(reg_write_en_Q104H), 32'd0);

    // reset while waiting for grant, then a stray rvalid
    c = mk(1, 1, 0, MEM_W, 0, WB_MEM, 5'd9, 1);
    nxt_ctrl = c; nxt_alu = 32'h40; nxt_sd = 32'h0; nxt_pc = 32'h200; nxt_rst = 1'b0;
    nxt_gnt = 1'b0; nxt_rvalid = 1'b0; nxt_rdata = $urandom;
    exp_req = 1'b1; exp_stall = 1'b1; exp_addr = 32'h40; exp_dwe = 1'b0;
    exp_be = 4'hF; exp_wd = 32'h0; np_we = 1'b0; np_mis = 1'b0;
    step();
    nxt_rst = 1'b1; exp_req = 1'b0; exp_stall = 1'b0;
    step();
    idle(1'b1);
    chk("rst_mid_wb_data", wb_data_Q104H, 32'h0);
    chk("rst_mid_reg_dst", 32'(reg_dst_Q104H), 32'h0);
    idle(1'b1);
    run_instr(mk(1, 0, 0, MEM_W, 0, WB_ALU, 5'd4, 1), 32'h0, 32'hCAFE_0001, 32'h0, 0, 1);
    idle(1'b0);
    chk("post_rst_alu", wb_data_Q104H, 32'hCAFE_0001);

    // randomised instruction stream
    for (int n = 0; n < 500; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      c = mk(($urandom_range(0, 7) != 0), (kind == 1), (kind == 2),
             t_mem_size'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             WB_ALU, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if (kind == 0) c.wb_sel_Q103H = ($urandom_range(0, 1) != 0) ? WB_PC4 : WB_ALU;
      if (kind == 1) c.wb_sel_Q103H = WB_MEM;
      if (kind != 0 && $urandom_range(0, 3) != 0) begin
        if (c.mem_size_Q103H == MEM_H) a[0] = 1'b0;
        if (c.mem_size_Q103H == MEM_W) a[1:0] = 2'b00;
      end
      run_instr(c, ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                a, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) idle(1'($urandom_range(0, 1)));
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
